// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI arbiter.
package oled_pkg;

   localparam int OLED_BYTE_W = 8;

   // Arbiter FSM: a packet walks IDLE -> SETUP -> SEND -> DRAIN -> GAP -> IDLE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SEND  = 3'd2,
      DRAIN = 3'd3,
      GAP   = 3'd4
   } arb_state_t;

endpackage

// File: rtl/oled_rr_picker.sv
// Combinational winner selection: round-robin from a pointer, or fixed
// priority with index 0 highest. Output is one-hot, zero when nothing requests.
module oled_rr_picker #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   input  logic                     fixed_i,
   output logic [N_REQ-1:0]         win_o
);

   localparam int PTR_W = $clog2(N_REQ);

   logic found;
   int   idx;

   // Scan from the pointer (or from 0 in fixed mode) and take the first requester.
   always_comb begin
      win_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = fixed_i ? k : ((int'(ptr_i) + k) % N_REQ);
         if (!found && req_i[idx[PTR_W-1:0]]) begin
            win_o[idx[PTR_W-1:0]] = 1'b1;
            found                 = 1'b1;
         end
      end
   end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Shares one OLED SPI byte transmitter between N_REQ packet sources.
// Whole packets are granted; cs_n and the setup/gap timing around each packet
// are owned here. Handshakes: a byte moves when valid and ready are both high
// in the same cycle; the granted requester sees tx_ready on its req_ready and
// its valid/data/dc pass straight through to the engine while in SEND.
module oled_spi_arbiter
   import oled_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int DATA_W     = OLED_BYTE_W,
   parameter int FIXED_PRIO = 0,
   parameter int CS_SETUP   = 1,
   parameter int CS_GAP     = 2
) (
   input  logic                      sclk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_dc,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_dc,
   input  logic                      tx_ready,
   input  logic                      tx_idle,
   output logic                      cs_n,
   output logic [N_REQ-1:0]          grant,
   output logic                      busy,
   output arb_state_t                dbg_state
);

   localparam int PTR_W   = $clog2(N_REQ);
   localparam int CNT_MAX = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = (CS_SETUP > 0) ? CNT_W'(CS_SETUP - 1) : '0;
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_GAP - 1);

   arb_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] gidx_q;
   logic [N_REQ-1:0] grant_q;
   logic             cs_n_q;

   logic [N_REQ-1:0] win_d;
   logic [PTR_W-1:0] win_idx_d;
   logic             last_sel;
   logic             hs;

   oled_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .fixed_i (FIXED_PRIO != 0),
      .win_o   (win_d)
   );

   // One-hot winner to binary index for the pass-through mux.
   always_comb begin
      win_idx_d = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_d[k]) win_idx_d = PTR_W'(k);
      end
   end

   // Pass-through of the granted requester to the engine, only while in SEND.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_dc     = 1'b0;
      req_ready = '0;
      last_sel  = 1'b0;
      if (state_q == SEND) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (gidx_q == PTR_W'(k)) begin
               tx_valid     = req_valid[k];
               tx_data      = req_data[k*DATA_W +: DATA_W];
               tx_dc        = req_dc[k];
               last_sel     = req_last[k];
               req_ready[k] = tx_ready;
            end
         end
      end
   end

   assign hs = tx_valid && tx_ready;

   // Packet FSM with the shared setup/gap counter and round-robin pointer.
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gidx_q  <= '0;
         grant_q <= '0;
         cs_n_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  grant_q <= win_d;
                  gidx_q  <= win_idx_d;
                  cs_n_q  <= 1'b0;
                  cnt_q   <= SETUP_LOAD;
                  state_q <= (CS_SETUP == 0) ? SEND : SETUP;
               end
            end
            SETUP: begin
               if (cnt_q == '0) begin
                  state_q <= SEND;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            SEND: begin
               if (hs && last_sel) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end
            end
            DRAIN: begin
               // Hold cs_n low until the shifter has pushed out the final bit.
               if (tx_idle) begin
                  cs_n_q  <= 1'b1;
                  grant_q <= '0;
                  ptr_q   <= (int'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + PTR_W'(1);
                  cnt_q   <= GAP_LOAD;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_n_q  <= 1'b1;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign cs_n      = cs_n_q;
   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

   a_grant_onehot0: assert property (@(posedge sclk) disable iff (!rst_n) $onehot0(grant_q));
   a_cs_high_idle:  assert property (@(posedge sclk) disable iff (!rst_n) cs_n_q |-> !tx_valid);
   a_dc_stable:     assert property (@(posedge sclk) disable iff (!rst_n)
                                     (tx_valid && !tx_ready) |=> (!tx_valid || $stable(tx_dc)));

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Bench for oled_spi_arbiter: one round-robin and one fixed-priority instance,
// random packets, a packet-level arbitration model and a byte scoreboard.
module tb_oled_spi_arbiter;
   import oled_pkg::*;

   localparam int N        = 2;
   localparam int W        = 8;
   localparam int CS_SETUP = 1;
   localparam int CS_GAP   = 2;
   localparam int RW       = W + 2;  // {last, dc, data}
   localparam int EW       = W + 3;  // {owner, last, dc, data}

   // ---------------- clock / reset ----------------
   logic sclk = 1'b0;
   logic rst_n;
   always #5 sclk = ~sclk;

   logic [N-1:0]   req_valid [2];
   logic [N*W-1:0] req_data  [2];
   logic [N-1:0]   req_dc    [2];
   logic [N-1:0]   req_last  [2];
   logic [N-1:0]   req_ready [2];
   logic           tx_valid  [2];
   logic [W-1:0]   tx_data   [2];
   logic           tx_dc     [2];
   logic           tx_ready  [2];
   logic           tx_idle   [2];
   logic           cs_n      [2];
   logic [N-1:0]   grant     [2];
   logic           busy      [2];
   arb_state_t     dbg_state [2];

   oled_spi_arbiter #(.N_REQ(N), .DATA_W(W), .FIXED_PRIO(0), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) u_rr (
      .sclk(sclk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_data(req_data[0]), .req_dc(req_dc[0]), .req_last(req_last[0]),
      .req_ready(req_ready[0]), .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_dc(tx_dc[0]),
      .tx_ready(tx_ready[0]), .tx_idle(tx_idle[0]), .cs_n(cs_n[0]), .grant(grant[0]),
      .busy(busy[0]), .dbg_state(dbg_state[0])
   );

   oled_spi_arbiter #(.N_REQ(N), .DATA_W(W), .FIXED_PRIO(1), .CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) u_fp (
      .sclk(sclk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_data(req_data[1]), .req_dc(req_dc[1]), .req_last(req_last[1]),
      .req_ready(req_ready[1]), .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_dc(tx_dc[1]),
      .tx_ready(tx_ready[1]), .tx_idle(tx_idle[1]), .cs_n(cs_n[1]), .grant(grant[1]),
      .busy(busy[1]), .dbg_state(dbg_state[1])
   );

   // ---------------- bench state ----------------
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [RW-1:0] rq [N][$];   // pending bytes per requester
   logic [EW-1:0] exp_q[$];    // expected engine-side bytes, in order
   int mdl_ptr [2];
   int hold [N];
   int rdy_low, eng_busy, hs_n, rdy_stall_at, drop_at;
   bit rdy_rand;
   bit in_pkt, drain, post, seen_valid;
   int owner, setup_cnt, hi_cnt, run_cyc, first_low;
   logic prev_v, prev_r, prev_dc;
   logic [W-1:0] prev_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic add_pkt(input int r, input int len);
      logic [W-1:0] d;
      logic dc;
      for (int b = 0; b < len; b++) begin
         d  = W'($urandom_range(0, 255));
         dc = 1'($urandom_range(0, 1));
         rq[r].push_back({(b == len - 1), dc, d});
      end
   endtask

   // Packet-level reference: pick winners by the arbitration rule among
   // requesters that still hold packets, and lay their bytes out whole.
   task automatic build_model(input int s, input bit fixed);
      int pos [N];
      int w, idx;
      logic [RW-1:0] e;
      for (int i = 0; i < N; i++) pos[i] = 0;
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++) begin
            idx = fixed ? k : (mdl_ptr[s] + k) % N;
            if (w < 0 && pos[idx] < rq[idx].size()) w = idx;
         end
         if (w < 0) break;
         do begin
            e = rq[w][pos[w]];
            exp_q.push_back({1'(w), e});
            pos[w]++;
         end while (!e[W+1] && pos[w] < rq[w].size());
         mdl_ptr[s] = (w + 1) % N;
      end
   endtask

   // One clock: drive at the falling edge, observe, then advance the models.
   task automatic cyc(input int s);
      int gi;
      bit hs;
      logic [EW-1:0] e;
      @(negedge sclk);
      for (int i = 0; i < N; i++) begin
         req_valid[s][i] = (rq[i].size() > 0) && (hold[i] == 0);
         if (rq[i].size() > 0) begin
            req_data[s][i*W +: W] = rq[i][0][W-1:0];
            req_dc[s][i]          = rq[i][0][W];
            req_last[s][i]        = rq[i][0][W+1];
         end
      end
      tx_ready[s] = (rdy_low > 0) ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      tx_idle[s]  = (eng_busy == 0);
      #1;
      run_cyc++;
      gi = oh_idx(grant[s]);
      chk("cs_high_no_valid", 32'(cs_n[s] && tx_valid[s]), 0);
      chk("grant_onehot0", 32'($onehot0(grant[s])), 1);
      chk("ready_only_granted", 32'(req_ready[s] & ~grant[s]), 0);
      if (post) begin
         chk("cs_up_after_drain", 32'(cs_n[s]), 1);
         chk("grant_clear_after_drain", 32'(grant[s]), 0);
         post = 0;
      end
      if (drain) begin
         chk("drain_cs_low", 32'(cs_n[s]), 0);
         chk("drain_no_valid", 32'(tx_valid[s]), 0);
         if (tx_idle[s]) begin
            drain = 0;
            post  = 1;
         end
      end
      if (in_pkt) begin
         chk("pkt_cs_low", 32'(cs_n[s]), 0);
         chk("pkt_grant_held", gi, owner);
         chk("pkt_ready_pass", 32'(req_ready[s]), tx_ready[s] ? 32'(N'(1) << owner) : 32'd0);
      end
      if (prev_v && !prev_r && tx_valid[s]) begin
         chk("stall_data_stable", 32'(tx_data[s]), 32'(prev_data));
         chk("stall_dc_stable", 32'(tx_dc[s]), 32'(prev_dc));
      end
      if (cs_n[s]) begin
         hi_cnt++;
         seen_valid = 0;
         setup_cnt  = 0;
      end else begin
         if (hi_cnt > 0) begin
            chk("gap_len_min", 32'(hi_cnt >= CS_GAP), 1);
            if (first_low < 0) first_low = run_cyc;
         end
         hi_cnt = 0;
         if (!seen_valid) begin
            if (tx_valid[s]) begin
               chk("setup_len", setup_cnt, CS_SETUP);
               seen_valid = 1;
            end else begin
               setup_cnt++;
            end
         end
      end
      hs = tx_valid[s] && tx_ready[s];
      for (int i = 0; i < N; i++) begin
         if (req_valid[s][i] && req_ready[s][i] && rq[i].size() > 0) void'(rq[i].pop_front());
         if (hold[i] > 0) hold[i]--;
      end
      if (rdy_low > 0) rdy_low--;
      if (hs) begin
         hs_n++;
         chk("byte_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data[s]), 32'(e[W-1:0]));
            chk("tx_dc", 32'(tx_dc[s]), 32'(e[W]));
            chk("tx_owner", gi, 32'(e[W+2]));
            if (!in_pkt) begin
               in_pkt = 1;
               owner  = int'(e[W+2]);
            end
            if (e[W+1]) begin
               in_pkt = 0;
               drain  = 1;
            end
            if (hs_n == rdy_stall_at) rdy_low = 5;
            if (hs_n == drop_at && !e[W+1]) hold[int'(e[W+2])] = 10;
         end
         eng_busy = $urandom_range(1, 3);
      end else if (eng_busy > 0) begin
         eng_busy--;
      end
      prev_v    = tx_valid[s];
      prev_r    = tx_ready[s];
      prev_data = tx_data[s];
      prev_dc   = tx_dc[s];
   endtask

   task automatic run(input int s, input bit fixed);
      build_model(s, fixed);
      run_cyc   = 0;
      first_low = -1;
      for (int c = 0; c < 400 && (exp_q.size() > 0 || drain || post); c++) cyc(s);
      chk("run_complete", exp_q.size() + int'(drain) + int'(post), 0);
      chk("req_side_drained", rq[0].size() + rq[1].size(), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
      drain  = 0;
      post   = 0;
      in_pkt = 0;
      repeat (3) cyc(s);
      chk("req_to_cs_latency", first_low, 2);
      chk("idle_after_run", 32'(busy[s]), 0);
      chk("cs_high_after_run", 32'(cs_n[s]), 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n        = 1'b0;
      rdy_rand     = 0;
      rdy_low      = 0;
      eng_busy     = 0;
      hs_n         = 0;
      rdy_stall_at = -1;
      drop_at      = -1;
      in_pkt       = 0;
      drain        = 0;
      post         = 0;
      seen_valid   = 0;
      owner        = 0;
      setup_cnt    = 0;
      hi_cnt       = 100;
      prev_v       = 0;
      prev_r       = 0;
      prev_dc      = 0;
      prev_data    = '0;
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int s = 0; s < 2; s++) begin
         mdl_ptr[s]   = 0;
         req_valid[s] = '0;
         req_data[s]  = '0;
         req_dc[s]    = '0;
         req_last[s]  = '0;
         tx_ready[s]  = 1'b0;
         tx_idle[s]   = 1'b1;
      end

      // Reset values on both instances.
      repeat (3) @(negedge sclk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_cs_n", 32'(cs_n[s]), 1);
         chk("rst_grant", 32'(grant[s]), 0);
         chk("rst_req_ready", 32'(req_ready[s]), 0);
         chk("rst_tx_valid", 32'(tx_valid[s]), 0);
         chk("rst_tx_data", 32'(tx_data[s]), 0);
         chk("rst_tx_dc", 32'(tx_dc[s]), 0);
         chk("rst_busy", 32'(busy[s]), 0);
         chk("rst_state", 32'(dbg_state[s]), 32'(IDLE));
      end
      rst_n = 1'b1;

      // Single 3-byte packet, engine always ready.
      add_pkt(0, 3);
      run(0, 0);

      // Both requesters competing, round-robin, mixed lengths incl. one byte.
      rdy_rand = 1;
      add_pkt(0, 3);
      add_pkt(1, 1);
      add_pkt(0, 2);
      add_pkt(1, 4);
      run(0, 0);

      // Fixed priority: req0 keeps packets queued, req1 waits for it.
      add_pkt(0, 2);
      add_pkt(0, 3);
      add_pkt(0, 2);
      add_pkt(1, 3);
      run(1, 1);

      // Engine stalls for 5 cycles mid-packet.
      rdy_stall_at = hs_n + 2;
      add_pkt(0, 6);
      add_pkt(1, 6);
      run(0, 0);
      rdy_stall_at = -1;

      // Granted requester drops valid for 10 cycles mid-packet.
      drop_at = hs_n + 2;
      add_pkt(0, 5);
      add_pkt(1, 5);
      run(0, 0);
      drop_at = -1;

      // Random traffic.
      repeat (4) begin
         for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 2)) add_pkt(i, $urandom_range(1, 5));
         end
         if (rq[0].size() == 0 && rq[1].size() == 0) add_pkt(1, 1);
         run(0, 0);
      end

      // Reset during SEND: leave the pointer at 1, start a req1 packet, abort it.
      add_pkt(0, 1);
      run(0, 0);
      add_pkt(1, 6);
      build_model(0, 0);
      for (int c = 0; c < 20 && !in_pkt; c++) cyc(0);
      chk("reached_send", 32'(in_pkt), 1);
      @(negedge sclk);
      rst_n = 1'b0;
      @(negedge sclk);
      #1;
      chk("midrst_cs_n", 32'(cs_n[0]), 1);
      chk("midrst_grant", 32'(grant[0]), 0);
      chk("midrst_tx_valid", 32'(tx_valid[0]), 0);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_req_ready", 32'(req_ready[0]), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         rq[i].delete();
         hold[i] = 0;
      end
      in_pkt     = 0;
      drain      = 0;
      post       = 0;
      seen_valid = 0;
      prev_v     = 0;
      hi_cnt     = 100;
      eng_busy   = 0;
      rdy_low    = 0;
      mdl_ptr[0] = 0;
      req_valid[0] = '0;
      rst_n = 1'b1;
      add_pkt(0, 2);
      add_pkt(1, 2);
      run(0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
